// File: rtl/imem_line_loader.sv
// Packs 48-bit instruction words five to a line and writes each line to the
// instruction memory's wide port at consecutive line addresses.
module imem_line_loader #(
    parameter int                WORD_W         = 48,
    parameter int                WORDS_PER_LINE = 5,
    parameter int                ADDR_W         = 8,
    parameter logic [WORD_W-1:0] PAD_WORD       = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WORD_W-1:0]                  in_data,
    input  logic                               in_last,
    output logic                               iMem_WEPin,
    output logic [ADDR_W-1:0]                  WEAddress,
    output logic [WORD_W*WORDS_PER_LINE-1:0]   idataWrite,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow,
    output logic [ADDR_W:0]                    lines_written
);

    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int SLOT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [SLOT_W-1:0]   r_slot;
    logic [LINE_W-1:0]   r_line;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_closed_last;
    logic                r_in_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_we_addr;
    logic [LINE_W-1:0]   r_we_data;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;
    logic [ADDR_W:0]     r_lines;

    logic                w_hs;
    logic                w_slot_full;
    logic                w_close;
    logic                w_addr_max;
    logic [LINE_W-1:0]   w_pad_line;
    logic [LINE_W-1:0]   w_line_merged;

    assign w_pad_line  = {WORDS_PER_LINE{PAD_WORD}};
    assign w_hs        = in_valid && r_in_ready;
    assign w_slot_full = (r_slot == SLOT_W'(WORDS_PER_LINE - 1));
    assign w_close     = w_hs && (w_slot_full || in_last);
    assign w_addr_max  = (r_addr == {ADDR_W{1'b1}});

    // Current line with the incoming word dropped into its slot; this is what
    // gets written when the handshake closes the line.
    always_comb begin
        w_line_merged = r_line;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_line_merged[i*WORD_W +: WORD_W] = in_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FILL;
            S_FILL:  if (w_close) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = (r_closed_last || w_addr_max) ? S_DONE : S_FILL;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_slot        <= '0;
            r_line        <= w_pad_line;
            r_addr        <= '0;
            r_closed_last <= 1'b0;
            r_in_ready    <= 1'b0;
            r_we          <= 1'b0;
            r_we_addr     <= '0;
            r_we_data     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_lines       <= '0;
        end else begin
            // Control outputs decode the upcoming state so they line up with it.
            r_in_ready <= (w_state_nxt == S_FILL);
            r_we       <= (w_state_nxt == S_WRITE);
            r_done     <= (w_state_nxt == S_DONE);
            r_busy     <= (w_state_nxt == S_FILL) || (w_state_nxt == S_WRITE);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= base_addr;
                        r_overflow <= 1'b0;
                        r_lines    <= '0;
                        r_slot     <= '0;
                        r_line     <= w_pad_line;
                    end
                end
                S_FILL: begin
                    if (w_hs) begin
                        r_line <= w_line_merged;
                        if (w_close) begin
                            r_closed_last <= in_last;
                            r_we_addr     <= r_addr;
                            r_we_data     <= w_line_merged;
                        end else begin
                            r_slot <= r_slot + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_lines <= r_lines + 1'b1;
                    if (!r_closed_last) begin
                        // Line 255 filled with more program pending: stop, never wrap.
                        if (w_addr_max) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                            r_slot <= '0;
                            r_line <= w_pad_line;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign iMem_WEPin    = r_we;
    assign WEAddress     = r_we_addr;
    assign idataWrite    = r_we_data;
    assign busy          = r_busy;
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign lines_written = r_lines;

endmodule

// File: tb/tb_imem_line_loader.sv
// Randomized and directed loads of imem_line_loader checked against a line-level
// model of the expected memory writes.
module tb_imem_line_loader;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   base_addr;
    logic         in_valid;
    logic         in_ready;
    logic [47:0]  in_data;
    logic         in_last;
    logic         iMem_WEPin;
    logic [7:0]   WEAddress;
    logic [239:0] idataWrite;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [8:0]   lines_written;

    imem_line_loader dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .iMem_WEPin    (iMem_WEPin),
        .WEAddress     (WEAddress),
        .idataWrite    (idataWrite),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .lines_written (lines_written)
    );

    always #5 clock = ~clock;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cnt;

    logic [47:0]  wq[$];
    logic [239:0] exp_lines[$];
    logic [7:0]   got_addr[$];
    logic [239:0] got_data[$];
    int           got_cyc[$];
    int           close_cyc[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (iMem_WEPin) begin
            got_addr.push_back(WEAddress);
            got_data.push_back(idataWrite);
            got_cyc.push_back(cyc);
            check("in_ready_during_write", {255'd0, in_ready}, 256'd0);
        end
        if (done) done_cnt++;
    end

    // gaps: 0 = back-to-back, 1 = valid every other cycle, 2 = random valid
    task automatic run_load(input logic [7:0] base, input bit last, input int gaps, input bit stray);
        int n, cap, acc, i, cycles, k;
        bit exp_ovf, fin, hs, stray_done;
        logic [239:0] ln;

        n   = wq.size();
        cap = (256 - int'(base)) * 5;
        acc = (n < cap) ? n : cap;
        exp_ovf = (n > cap);
        exp_lines.delete();
        ln = '0;
        for (int j = 0; j < acc; j++) begin
            ln[(j % 5) * 48 +: 48] = wq[j];
            if ((j % 5 == 4) || (j == acc - 1)) begin
                exp_lines.push_back(ln);
                ln = '0;
            end
        end

        got_addr.delete(); got_data.delete(); got_cyc.delete(); close_cyc.delete();
        done_cnt = 0;
        start = 1'b1; base_addr = base;
        @(posedge clock); #1;
        start = 1'b0;
        i = 0; cycles = 0; fin = 0; stray_done = 0;
        while (!fin && cycles < 3000) begin
            case (gaps)
                0:       in_valid = (i < n);
                1:       in_valid = (i < n) && cycles[0];
                default: in_valid = (i < n) && ($urandom_range(0, 1) == 1);
            endcase
            in_data = (i < n) ? wq[i] : 48'h0;
            in_last = last && (i == n - 1);
            if (stray && i == 2 && !stray_done) begin
                start = 1'b1; base_addr = 8'h99; stray_done = 1;
            end
            @(negedge clock);
            hs = in_valid && in_ready;
            if (hs && ((i % 5 == 4) || in_last)) close_cyc.push_back(cyc);
            if (done) fin = 1;
            @(posedge clock); #1;
            start = 1'b0;
            if (hs) i++;
            cycles++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);

        check("done_seen", {255'd0, fin}, 256'd1);
        check("done_pulses", 256'(done_cnt), 256'd1);
        check("words_accepted", 256'(i), 256'(acc));
        check("write_count", 256'(got_addr.size()), 256'(exp_lines.size()));
        for (k = 0; k < exp_lines.size() && k < got_addr.size(); k++) begin
            check("write_addr", 256'(got_addr[k]), 256'(int'(base) + k));
            check("write_data", 256'(got_data[k]), 256'(exp_lines[k]));
            if (k < close_cyc.size())
                check("write_latency", 256'(got_cyc[k] - close_cyc[k]), 256'd1);
        end
        check("lines_written", 256'(lines_written), 256'(exp_lines.size()));
        check("overflow", {255'd0, overflow}, {255'd0, exp_ovf});
        check("idle_in_ready", {255'd0, in_ready}, 256'd0);
        check("idle_busy", {255'd0, busy}, 256'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = 8'h0;
        in_valid = 1'b0; in_data = 48'h0; in_last = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", {255'd0, in_ready}, 256'd0);
        check("rst_we", {255'd0, iMem_WEPin}, 256'd0);
        check("rst_addr", 256'(WEAddress), 256'd0);
        check("rst_data", 256'(idataWrite), 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_done", {255'd0, done}, 256'd0);
        check("rst_overflow", {255'd0, overflow}, 256'd0);
        check("rst_lines", 256'(lines_written), 256'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        wq.delete(); for (int j = 1; j <= 10; j++) wq.push_back(48'(j));
        run_load(8'h10, 1'b1, 0, 1'b0);

        wq.delete(); for (int j = 0; j < 7; j++) wq.push_back(48'h100 + 48'(j));
        run_load(8'h20, 1'b1, 0, 1'b0);

        wq.delete(); for (int j = 1; j <= 6; j++) wq.push_back(48'(j));
        run_load(8'hFF, 1'b0, 0, 1'b0);

        wq.delete(); for (int j = 1; j <= 5; j++) wq.push_back(48'(j));
        run_load(8'h30, 1'b1, 1, 1'b1);

        // Abort mid-load; start coincides with the reset cycle and must lose.
        got_addr.delete();
        start = 1'b1; base_addr = 8'h40;
        @(posedge clock); #1;
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_data = 48'hDEAD00 + 48'(j); in_last = 1'b0;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1; start = 1'b1; base_addr = 8'h55;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        check("abort_we", {255'd0, iMem_WEPin}, 256'd0);
        check("abort_busy", {255'd0, busy}, 256'd0);
        check("abort_in_ready", {255'd0, in_ready}, 256'd0);
        repeat (3) @(negedge clock);
        check("abort_no_write", 256'(got_addr.size()), 256'd0);
        check("abort_busy_later", {255'd0, busy}, 256'd0);
        @(posedge clock); #1;

        wq.delete(); for (int j = 0; j < 5; j++) wq.push_back(48'hA000 + 48'(j));
        run_load(8'h00, 1'b1, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            wq.delete();
            for (int j = 0; j < $urandom_range(1, 14); j++)
                wq.push_back({$urandom(), 16'($urandom())});
            run_load(8'($urandom_range(0, 250)), 1'b1, 2, t[0]);
        end

        wq.delete(); for (int j = 0; j < 20; j++) wq.push_back({$urandom(), 16'($urandom())});
        run_load(8'hFD, 1'b1, 2, 1'b0);

        wq.delete(); for (int j = 0; j < 15; j++) wq.push_back({$urandom(), 16'($urandom())});
        run_load(8'hFD, 1'b1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
